// File: rtl/dac_frame_sequencer_4ch.sv
// Frame sequencer for a 4-channel DAC SPI driver.
// Channel-tagged samples are collected into a staging bank. On each frame tick,
// a complete frame is committed atomically to four held output words.
module dac_frame_sequencer_4ch #(
    parameter int TICK_DIV  = 1000,
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic        clk100mhz,
    input  logic        rst,
    input  logic        i_enable,
    input  logic [15:0] i_sample,
    input  logic [1:0]  i_channel,
    input  logic        i_last,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [15:0] o_data_ch0,
    output logic [15:0] o_data_ch1,
    output logic [15:0] o_data_ch2,
    output logic [15:0] o_data_ch3,
    output logic        o_ce,
    output logic        o_frame_commit,
    output logic        o_underrun,
    input  logic        i_clear_underrun,
    output logic [15:0] o_frame_count
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [15:0] MIDSCALE  = 16'h8000;

    typedef enum logic {FILL, PENDING} state_t;

    state_t            state_reg, state_next;
    logic [15:0]       tick_cnt_reg, tick_cnt_next;
    logic              tick;
    logic              run_reg;
    logic [3:0][15:0]  stage_reg;
    logic [3:0][15:0]  data_reg;
    logic [3:0][15:0]  merged;
    logic [15:0]       conv_sample;
    logic              accept, last_beat, commit, underrun_set;
    logic              ce_reg, ce_next;
    logic              underrun_reg, underrun_next;
    logic              commit_reg;
    logic [15:0]       count_reg;

    assign conv_sample = SIGNED_IN ? {~i_sample[15], i_sample[14:0]} : i_sample;
    assign o_ready     = run_reg && (state_reg == FILL);
    assign accept      = i_valid && o_ready;
    assign last_beat   = accept && i_last;

    // Staging contents as they would look after this cycle's beat; a commit
    // in the same cycle as the final beat therefore includes that beat.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merged[gi] = (accept && (i_channel == 2'(gi))) ? conv_sample : stage_reg[gi];
        end
    endgenerate

    // Frame-rate tick: free-runs while enabled, held at zero otherwise.
    always_comb begin
        tick          = i_enable && (tick_cnt_reg == TICK_LAST);
        tick_cnt_next = (!i_enable || tick) ? 16'd0 : tick_cnt_reg + 16'd1;
    end

    // Next-state logic: decides commits, late-frame events and FILL/PENDING.
    always_comb begin
        state_next   = state_reg;
        commit       = 1'b0;
        underrun_set = 1'b0;
        case (state_reg)
            FILL: begin
                if (last_beat) begin
                    if (tick) commit = 1'b1;
                    else      state_next = PENDING;
                end else if (tick && ce_reg) begin
                    underrun_set = 1'b1;
                end
            end
            PENDING: begin
                if (tick) begin
                    commit     = 1'b1;
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Enable and sticky-flag next values; a set beats a same-cycle clear.
    always_comb begin
        ce_next       = commit ? 1'b1 : (i_enable ? ce_reg : 1'b0);
        underrun_next = underrun_set ? 1'b1 : (i_clear_underrun ? 1'b0 : underrun_reg);
    end

    // State, counters and flags.
    always_ff @(posedge clk100mhz) begin
        if (rst) begin
            state_reg    <= FILL;
            tick_cnt_reg <= 16'd0;
            run_reg      <= 1'b0;
            ce_reg       <= 1'b0;
            underrun_reg <= 1'b0;
            commit_reg   <= 1'b0;
            count_reg    <= 16'd0;
        end else begin
            state_reg    <= state_next;
            tick_cnt_reg <= tick_cnt_next;
            run_reg      <= 1'b1;
            ce_reg       <= ce_next;
            underrun_reg <= underrun_next;
            commit_reg   <= commit;
            if (commit) count_reg <= count_reg + 16'd1;
        end
    end

    // Staging bank and held output words; all four outputs move together.
    always_ff @(posedge clk100mhz) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                stage_reg[i] <= MIDSCALE;
                data_reg[i]  <= MIDSCALE;
            end else begin
                stage_reg[i] <= merged[i];
                if (commit) data_reg[i] <= merged[i];
            end
        end
    end

    assign o_data_ch0     = data_reg[0];
    assign o_data_ch1     = data_reg[1];
    assign o_data_ch2     = data_reg[2];
    assign o_data_ch3     = data_reg[3];
    assign o_ce           = ce_reg;
    assign o_underrun     = underrun_reg;
    assign o_frame_commit = commit_reg;
    assign o_frame_count  = count_reg;

endmodule

// File: tb/tb_dac_frame_sequencer_4ch.sv
// Bench for dac_frame_sequencer_4ch: frame-level reference model, conversion
// table, hand sequences for the corner cases and a randomized soak.
module tb_dac_frame_sequencer_4ch;

    localparam int TICK_DIV  = 10;
    localparam bit SIGNED_IN = 1'b1;

    logic        clk100mhz = 1'b0;
    logic        rst = 1'b1;
    logic        i_enable = 1'b0;
    logic [15:0] i_sample = '0;
    logic [1:0]  i_channel = '0;
    logic        i_last = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_clear_underrun = 1'b0;
    logic        o_ready, o_ce, o_frame_commit, o_underrun;
    logic [15:0] o_data_ch0, o_data_ch1, o_data_ch2, o_data_ch3, o_frame_count;

    always #5 clk100mhz = ~clk100mhz;

    dac_frame_sequencer_4ch #(.TICK_DIV(TICK_DIV), .SIGNED_IN(SIGNED_IN)) dut (
        .clk100mhz(clk100mhz), .rst(rst), .i_enable(i_enable),
        .i_sample(i_sample), .i_channel(i_channel), .i_last(i_last),
        .i_valid(i_valid), .o_ready(o_ready),
        .o_data_ch0(o_data_ch0), .o_data_ch1(o_data_ch1),
        .o_data_ch2(o_data_ch2), .o_data_ch3(o_data_ch3),
        .o_ce(o_ce), .o_frame_commit(o_frame_commit), .o_underrun(o_underrun),
        .i_clear_underrun(i_clear_underrun), .o_frame_count(o_frame_count)
    );

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;

    // Reference model: a frame buffer with a "closed" flag, enabled-run length
    // giving the tick phase, committed words and bookkeeping.
    bit          m_started = 1'b0, m_closed = 1'b0, m_ce = 1'b0, m_under = 1'b0, m_pulse = 1'b0;
    logic [15:0] m_stage [4];
    logic [15:0] m_out [4];
    int          m_count = 0;
    int          m_run = 0;

    typedef struct {
        logic [1:0]  ch;
        logic [15:0] sample;
        logic [15:0] exp;
    } vec_t;

    function automatic logic [15:0] conv_ref(input logic [15:0] s);
        logic [15:0] r;
        r = s + 16'h8000;
        return SIGNED_IN ? r : s;
    endfunction

    function automatic logic [15:0] get_out(input logic [1:0] ch);
        case (ch)
            2'd0:    return o_data_ch0;
            2'd1:    return o_data_ch1;
            2'd2:    return o_data_ch2;
            default: return o_data_ch3;
        endcase
    endfunction

    function automatic bit m_ready();
        return m_started && !m_closed;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_update(input bit r, input bit en, input bit v, input logic [1:0] ch,
                                input logic [15:0] smp, input bit last, input bit clr);
        bit tick, acc, fin, commit, set;
        if (r) begin
            m_started = 0; m_closed = 0; m_ce = 0; m_under = 0; m_pulse = 0;
            m_count = 0; m_run = 0;
            for (int i = 0; i < 4; i++) begin
                m_stage[i] = 16'h8000;
                m_out[i]   = 16'h8000;
            end
        end else begin
            tick   = en && ((m_run % TICK_DIV) == TICK_DIV - 1);
            acc    = v && m_ready();
            fin    = acc && last;
            if (acc) m_stage[ch] = conv_ref(smp);
            commit = tick && (m_closed || fin);
            set    = tick && !m_closed && !fin && m_ce;
            if (commit) begin
                for (int i = 0; i < 4; i++) m_out[i] = m_stage[i];
                m_count = (m_count + 1) % 65536;
            end
            if (commit)   m_closed = 0;
            else if (fin) m_closed = 1;
            m_pulse   = commit;
            m_ce      = commit ? 1'b1 : (en ? m_ce : 1'b0);
            m_under   = set ? 1'b1 : (clr ? 1'b0 : m_under);
            m_run     = en ? m_run + 1 : 0;
            m_started = 1;
        end
    endtask

    // One clock cycle: drive inputs, advance the model, compare after the edge.
    task automatic step(input bit r, input bit en, input bit v, input logic [1:0] ch,
                        input logic [15:0] smp, input bit last, input bit clr);
        rst = r; i_enable = en; i_valid = v; i_channel = ch;
        i_sample = smp; i_last = last; i_clear_underrun = clr;
        model_update(r, en, v, ch, smp, last, clr);
        @(posedge clk100mhz);
        @(negedge clk100mhz);
        cyc++;
        chk("data_ch0", o_data_ch0, m_out[0]);
        chk("data_ch1", o_data_ch1, m_out[1]);
        chk("data_ch2", o_data_ch2, m_out[2]);
        chk("data_ch3", o_data_ch3, m_out[3]);
        chk("ce", 16'(o_ce), 16'(m_ce));
        chk("frame_commit", 16'(o_frame_commit), 16'(m_pulse));
        chk("underrun", 16'(o_underrun), 16'(m_under));
        chk("frame_count", o_frame_count, 16'(m_count));
        chk("ready", 16'(o_ready), 16'(m_ready()));
    endtask

    task automatic idle();
        step(0, 1, 0, 2'd0, 16'h0, 0, 0);
    endtask

    task automatic send_beat(input logic [1:0] ch, input logic [15:0] smp, input bit last);
        for (int k = 0; k < 3 * TICK_DIV && !m_ready(); k++) idle();
        if (!m_ready()) begin
            n_vec++; n_miss++;
            $display("FAIL beat_wait_timeout at cycle %0d: ready never returned", cyc);
        end
        step(0, 1, 1, ch, smp, last, 0);
    endtask

    task automatic wait_commit();
        int k;
        for (k = 0; k < 3 * TICK_DIV && !m_pulse; k++) idle();
        n_vec++;
        if (!m_pulse) begin
            n_miss++;
            $display("FAIL commit_timeout at cycle %0d: no commit in %0d cycles", cyc, k);
        end
    endtask

    vec_t        tbl [8];
    logic [15:0] saved [4];
    logic [15:0] prior_ch1;
    int          t_prev;
    bit          en_r;

    initial begin
        tbl[0] = '{2'd0, 16'h0000, 16'h8000};
        tbl[1] = '{2'd1, 16'h7FFF, 16'hFFFF};
        tbl[2] = '{2'd2, 16'h8000, 16'h0000};
        tbl[3] = '{2'd3, 16'hFFFF, 16'h7FFF};
        tbl[4] = '{2'd0, 16'h1234, 16'h9234};
        tbl[5] = '{2'd1, 16'hFEDC, 16'h7EDC};
        tbl[6] = '{2'd2, 16'h0001, 16'h8001};
        tbl[7] = '{2'd3, 16'h8001, 16'h0001};

        @(negedge clk100mhz);
        step(1, 0, 0, 2'd0, 16'h0, 0, 0);
        step(1, 0, 0, 2'd0, 16'h0, 0, 0);
        chk("reset_ch0", o_data_ch0, 16'h8000);
        chk("reset_ready", 16'(o_ready), 16'd0);
        chk("reset_count", o_frame_count, 16'd0);
        idle();
        chk("ready_after_release", 16'(o_ready), 16'd1);

        // Basic frame with the conversion extremes.
        send_beat(2'd0, 16'h0000, 0);
        send_beat(2'd1, 16'h7FFF, 0);
        send_beat(2'd2, 16'h8000, 0);
        send_beat(2'd3, 16'hFFFF, 1);
        wait_commit();
        chk("t1_ch0", o_data_ch0, 16'h8000);
        chk("t1_ch1", o_data_ch1, 16'hFFFF);
        chk("t1_ch2", o_data_ch2, 16'h0000);
        chk("t1_ch3", o_data_ch3, 16'h7FFF);
        chk("t1_count", o_frame_count, 16'd1);
        chk("t1_ce", 16'(o_ce), 16'd1);

        // Back-to-back frames: commit every TICK_DIV cycles, not ready while pending.
        t_prev = cyc;
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < 4; c++)
                send_beat(2'(c), 16'($urandom), c == 3);
            chk("t2_ready_pending", 16'(o_ready), 16'd0);
            wait_commit();
            chk("t2_period", 16'(cyc - t_prev), 16'(TICK_DIV));
            t_prev = cyc;
        end

        // Starvation sets the sticky flag; a clear on a tick cycle loses.
        saved[0] = o_data_ch0; saved[1] = o_data_ch1;
        saved[2] = o_data_ch2; saved[3] = o_data_ch3;
        repeat (2 * TICK_DIV) idle();
        chk("t3_underrun_set", 16'(o_underrun), 16'd1);
        for (int i = 0; i < 4; i++) chk("t3_data_hold", get_out(2'(i)), saved[i]);
        step(0, 1, 0, 2'd0, 16'h0, 0, 1);
        chk("t3_underrun_clear", 16'(o_underrun), 16'd0);
        repeat (TICK_DIV - 2) idle();
        step(0, 1, 0, 2'd0, 16'h0, 0, 1);
        chk("t3_set_wins", 16'(o_underrun), 16'd1);
        step(0, 1, 0, 2'd0, 16'h0, 0, 1);
        chk("t3_underrun_clear2", 16'(o_underrun), 16'd0);

        // Final beat lands exactly in the tick cycle.
        send_beat(2'd0, 16'h1111, 0);
        send_beat(2'd1, 16'h2222, 0);
        send_beat(2'd2, 16'h3333, 0);
        for (int k = 0; k < 2 * TICK_DIV && (m_run % TICK_DIV) != TICK_DIV - 1; k++) idle();
        step(0, 1, 1, 2'd3, 16'h0F0F, 1, 0);
        chk("t4_commit", 16'(o_frame_commit), 16'd1);
        chk("t4_ch3", o_data_ch3, 16'h8F0F);
        chk("t4_no_underrun", 16'(o_underrun), 16'd0);
        chk("t4_stay_fill", 16'(o_ready), 16'd1);

        // Repeated channel overwrites, omitted channel keeps its value.
        prior_ch1 = o_data_ch1;
        send_beat(2'd0, 16'h0001, 0);
        send_beat(2'd2, 16'h1234, 0);
        send_beat(2'd3, 16'h4000, 0);
        send_beat(2'd2, 16'h5678, 1);
        wait_commit();
        chk("t5_ch2", o_data_ch2, 16'hD678);
        chk("t5_ch1_kept", o_data_ch1, prior_ch1);
        chk("t5_ch0", o_data_ch0, 16'h8001);
        chk("t5_ch3", o_data_ch3, 16'hC000);

        // Conversion table, one single-beat frame per entry.
        foreach (tbl[i]) begin
            send_beat(tbl[i].ch, tbl[i].sample, 1);
            wait_commit();
            chk("tbl_conv", get_out(tbl[i].ch), tbl[i].exp);
        end

        // Reset while pending.
        for (int c = 0; c < 4; c++) send_beat(2'(c), 16'($urandom), c == 3);
        chk("t6_pending", 16'(o_ready), 16'd0);
        step(1, 1, 0, 2'd0, 16'h0, 0, 0);
        for (int i = 0; i < 4; i++) chk("t6_midscale", get_out(2'(i)), 16'h8000);
        chk("t6_ce", 16'(o_ce), 16'd0);
        chk("t6_count", o_frame_count, 16'd0);
        chk("t6_ready", 16'(o_ready), 16'd0);
        idle();
        chk("t6_ready_release", 16'(o_ready), 16'd1);

        // Randomized soak against the model.
        en_r = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 59) == 0) en_r = !en_r;
            step($urandom_range(0, 299) == 0, en_r, $urandom_range(0, 1) == 1,
                 2'($urandom_range(0, 3)), 16'($urandom), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 19) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
